// File: rtl/debounce_bank_pkg.sv
// Shared types and elaboration-time checks for the debounce bank.
package bbc_pkg;

    // Sticky edge flags of one channel: filtered 0->1 (rise) and 1->0 (fall).
    typedef struct packed {
        logic rise;
        logic fall;
    } flags_t;

    // True when a counter of 'width' bits can reach 'count' without wrapping.
    function automatic bit count_fits(input int width, input int count);
        if (width < 1 || width > 32 || count < 0) begin
            return 1'b0;
        end
        return longint'(count) <= ((longint'(1) << width) - 1);
    endfunction

endpackage

// File: rtl/debounce_bank_if.sv
// Signal bundle between the debounce bank and the processor-facing logic.
interface debounce_bank_if #(
    parameter int CHANNELS = 8
);
    // No valid/ready handshake: CLK_en qualifies sampling, ACK is a level
    // sampled on every clock, and all outputs are valid on every cycle.
    logic                CLK_en;
    logic [CHANNELS-1:0] SIGNAL;
    logic [CHANNELS-1:0] ACK;
    logic [CHANNELS-1:0] RISE_MASK;
    logic [CHANNELS-1:0] FALL_MASK;
    logic [CHANNELS-1:0] FILTERED_SIGNAL;
    logic [CHANNELS-1:0] RISE;
    logic [CHANNELS-1:0] FALL;
    logic                CHANGED;
    logic                IRQ;

    modport master (
        output CLK_en, SIGNAL, ACK, RISE_MASK, FALL_MASK,
        input  FILTERED_SIGNAL, RISE, FALL, CHANGED, IRQ
    );

    modport slave (
        input  CLK_en, SIGNAL, ACK, RISE_MASK, FALL_MASK,
        output FILTERED_SIGNAL, RISE, FALL, CHANGED, IRQ
    );

endinterface

// File: rtl/debounce_bank_channel.sv
// One debounce channel: sample register, stability counter, filtered bit
// and sticky rise/fall flags.
module debounce_channel
    import bbc_pkg::*;
#(
    parameter int   COUNT_WIDTH    = 4,
    parameter int   DEBOUNCE_COUNT = 15,
    parameter logic PRESET         = 1'b0
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   en_i,
    input  logic   signal_i,
    input  logic   ack_i,
    output logic   filtered_o,
    output flags_t flags_o,
    output logic   update_o
);

    localparam logic [COUNT_WIDTH-1:0] LIMIT = COUNT_WIDTH'(DEBOUNCE_COUNT);

    logic                   last_q, last_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   filt_q, filt_d;
    flags_t                 flags_q, flags_d;
    logic                   at_limit;
    logic                   update;

    assign at_limit = (cnt_q == LIMIT);

    always_comb begin
        last_d  = last_q;
        cnt_d   = cnt_q;
        filt_d  = filt_q;
        flags_d = flags_q;
        update  = 1'b0;

        if (en_i) begin
            last_d = signal_i;
            if (at_limit || (signal_i != last_q)) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + COUNT_WIDTH'(1);
            end
            // Acceptance of an unchanged value is a silent reload.
            if (at_limit) begin
                filt_d = last_q;
                update = (last_q != filt_q);
            end
        end

        // Ack clears first so a same-edge set wins.
        if (ack_i) begin
            flags_d.rise = 1'b0;
            flags_d.fall = 1'b0;
        end
        if (update) begin
            if (last_q) begin
                flags_d.rise = 1'b1;
            end else begin
                flags_d.fall = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_q  <= PRESET;
            cnt_q   <= '0;
            filt_q  <= PRESET;
            flags_q <= '0;
        end else begin
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            filt_q  <= filt_d;
            flags_q <= flags_d;
        end
    end

    assign filtered_o = filt_q;
    assign flags_o    = flags_q;
    assign update_o   = update;

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel debouncer: per-channel filters, one CHANGED pulse for any
// filtered change, and a maskable interrupt from the sticky flags.
module debounce_bank
    import bbc_pkg::*;
#(
    parameter int                  CHANNELS       = 8,
    parameter int                  COUNT_WIDTH    = 4,
    parameter int                  DEBOUNCE_COUNT = 15,
    parameter logic [CHANNELS-1:0] PRESET_VALUE   = '0
) (
    input  logic            CLK,
    input  logic            nRESET,
    debounce_bank_if.slave  bus
);

    if (!count_fits(COUNT_WIDTH, DEBOUNCE_COUNT)) begin : g_bad_count
        $error("debounce_bank: DEBOUNCE_COUNT does not fit in COUNT_WIDTH bits");
    end
    if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
        $error("debounce_bank: CHANNELS must be in 1..32");
    end

    logic [CHANNELS-1:0] filt_v;
    logic [CHANNELS-1:0] update_v;
    logic [CHANNELS-1:0] rise_v;
    logic [CHANNELS-1:0] fall_v;
    flags_t              flags_v [CHANNELS];
    logic                changed_q, changed_d;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        debounce_channel #(
            .COUNT_WIDTH    (COUNT_WIDTH),
            .DEBOUNCE_COUNT (DEBOUNCE_COUNT),
            .PRESET         (PRESET_VALUE[i])
        ) u_chan (
            .clk_i      (CLK),
            .rst_ni     (nRESET),
            .en_i       (bus.CLK_en),
            .signal_i   (bus.SIGNAL[i]),
            .ack_i      (bus.ACK[i]),
            .filtered_o (filt_v[i]),
            .flags_o    (flags_v[i]),
            .update_o   (update_v[i])
        );
    end

    always_comb begin
        rise_v = '0;
        fall_v = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            rise_v[i] = flags_v[i].rise;
            fall_v[i] = flags_v[i].fall;
        end
    end

    // Simultaneous updates on several channels collapse into one pulse.
    assign changed_d = |update_v;

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= changed_d;
        end
    end

    assign bus.FILTERED_SIGNAL = filt_v;
    assign bus.RISE            = rise_v;
    assign bus.FALL            = fall_v;
    assign bus.CHANGED         = changed_q;
    assign bus.IRQ             = |((rise_v & bus.RISE_MASK) | (fall_v & bus.FALL_MASK));

endmodule
